hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage processor (F, D, X, M, W). It runs alongside the bypass logic and covers the hazards forwarding cannot: load-use stalls, taken-branch flushes, and multi-cycle mult/div execution.
- It drives the PC and latch write-enables, the bubble/flush controls, and the start/handshake to the shared mult/div unit.
- Decode fields throughout: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- Opcodes: 0 R-type, 5 addi, 7 sw, 8 lw, 2/6 branch, 4 jr. ALU op 6 = mult, 7 = div.

---
 rtl/hazard_stall_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing for the 5-stage core.
// Covers load-use stalls, taken-branch flushes and multi-cycle mult/div
// execution (IDLE -> WAIT -> DONE), driving PC/latch enables and the
// mult/div start/handshake.
// Optional feature macro: HAZARD_MD_TIMEOUT_EN (abort a mult/div that never
// returns md_ready after MD_TIMEOUT wait cycles, as an exception writeback).
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] FDIR,
  input  logic [31:0] DXIR,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        pc_we,
  output logic        fd_we,
  output logic        dx_bubble,
  output logic        fd_flush,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_busy,
  output logic        md_wb_valid,
  output logic        md_exc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (2**CNT_W <= MD_TIMEOUT) begin : g_cnt_w_too_small
    $error("CNT_W too narrow to reach MD_TIMEOUT");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctrl_mult_q, ctrl_mult_d;
  logic             ctrl_div_q, ctrl_div_d;
  logic             md_busy_q, md_busy_d;
  logic             md_wb_valid_q, md_wb_valid_d;
  logic             md_exc_q, md_exc_d;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       fd_uses_rs, fd_uses_rt, fd_uses_rd;
  logic       load_use, md_op;
  logic       unused_ir_bits;

  assign fd_op  = FDIR[31:27];
  assign fd_rd  = FDIR[26:22];
  assign fd_rs  = FDIR[21:17];
  assign fd_rt  = FDIR[16:12];
  assign dx_op  = DXIR[31:27];
  assign dx_rd  = DXIR[26:22];
  assign dx_alu = DXIR[6:2];

  assign unused_ir_bits = ^{FDIR[11:0], DXIR[21:7], DXIR[1:0]};

  // Which operand slots of the F/D instruction are register reads
  always_comb begin
    fd_uses_rs = (fd_op == 5'd0) || (fd_op == 5'd5) || (fd_op == 5'd7) || (fd_op == 5'd8);
    fd_uses_rt = (fd_op == 5'd0);
    fd_uses_rd = (fd_op == 5'd7) || (fd_op == 5'd2) || (fd_op == 5'd6) || (fd_op == 5'd4);
  end

  assign load_use = (dx_op == 5'd8) && (dx_rd != 5'd0) &&
                    ((fd_uses_rs && (fd_rs == dx_rd)) ||
                     (fd_uses_rt && (fd_rt == dx_rd)) ||
                     (fd_uses_rd && (fd_rd == dx_rd)));

  assign md_op = (dx_op == 5'd0) && ((dx_alu == 5'd6) || (dx_alu == 5'd7));

  // Pipeline enables: mult/div states own the pipe, else flush beats load-use
  always_comb begin
    pc_we     = 1'b1;
    fd_we     = 1'b1;
    dx_bubble = 1'b0;
    fd_flush  = 1'b0;
    case (state_q)
      S_WAIT: begin
        pc_we = 1'b0;
        fd_we = 1'b0;
      end
      S_DONE: begin
        // Bubble behind the finished op so the held mult/div is not reissued
        dx_bubble = 1'b1;
      end
      default: begin
        if (branch_taken) begin
          fd_flush  = 1'b1;
          dx_bubble = 1'b1;
        end else if (load_use) begin
          pc_we     = 1'b0;
          fd_we     = 1'b0;
          dx_bubble = 1'b1;
        end
      end
    endcase
  end

  // Mult/div sequencing: next state, cycle counter and registered handshakes
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctrl_mult_d   = 1'b0;
    ctrl_div_d    = 1'b0;
    md_busy_d     = md_busy_q;
    md_wb_valid_d = 1'b0;
    md_exc_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_op && !branch_taken) begin
          state_d     = S_WAIT;
          cnt_d       = '0;
          md_busy_d   = 1'b1;
          ctrl_mult_d = (dx_alu == 5'd6);
          ctrl_div_d  = (dx_alu == 5'd7);
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (md_ready) begin
          state_d       = S_DONE;
          md_busy_d     = 1'b0;
          md_wb_valid_d = 1'b1;
          md_exc_d      = md_exception;
        end
`ifdef HAZARD_MD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MD_TIMEOUT)) begin
          // Unit never answered: retire the op as an exception writeback
          state_d       = S_DONE;
          md_busy_d     = 1'b0;
          md_wb_valid_d = 1'b1;
          md_exc_d      = 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d   = S_IDLE;
        md_busy_d = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        md_busy_d = 1'b0;
      end
    endcase
  end

  // State and handshake registers; reset abandons any operation in flight
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ctrl_mult_q   <= 1'b0;
      ctrl_div_q    <= 1'b0;
      md_busy_q     <= 1'b0;
      md_wb_valid_q <= 1'b0;
      md_exc_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ctrl_mult_q   <= ctrl_mult_d;
      ctrl_div_q    <= ctrl_div_d;
      md_busy_q     <= md_busy_d;
      md_wb_valid_q <= md_wb_valid_d;
      md_exc_q      <= md_exc_d;
    end
  end

  assign ctrl_mult   = ctrl_mult_q;
  assign ctrl_div    = ctrl_div_q;
  assign md_busy     = md_busy_q;
  assign md_wb_valid = md_wb_valid_q;
  assign md_exc      = md_exc_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed bench with a behavioural model of the
// sequencing rules and per-cycle comparison of every output.
module tb_hazard_stall_ctrl;

  localparam int MD_TIMEOUT = 40;
  localparam int CNT_W      = 6;

  localparam logic [31:0] LW_R3   = 32'h40C0_0000;
  localparam logic [31:0] ADD_R3  = 32'h0106_5000;
  localparam logic [31:0] MULT_OP = 32'h0182_2018;
  localparam logic [31:0] DIV_OP  = 32'h0182_201C;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] FDIR, DXIR;
  logic        branch_taken, md_ready, md_exception;
  logic        pc_we, fd_we, dx_bubble, fd_flush;
  logic        ctrl_mult, ctrl_div, md_busy, md_wb_valid, md_exc;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  hazard_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .FDIR(FDIR), .DXIR(DXIR),
    .branch_taken(branch_taken), .md_ready(md_ready), .md_exception(md_exception),
    .pc_we(pc_we), .fd_we(fd_we), .dx_bubble(dx_bubble), .fd_flush(fd_flush),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_busy(md_busy),
    .md_wb_valid(md_wb_valid), .md_exc(md_exc)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  // Set of registers the instruction reads, asked one register at a time
  function automatic bit reads_reg(input logic [31:0] ir, input logic [4:0] r);
    int op;
    op = int'(ir[31:27]);
    return ((op inside {0, 5, 7, 8}) && ir[21:17] == r) ||
           ((op == 0) && ir[16:12] == r) ||
           ((op inside {7, 2, 6, 4}) && ir[26:22] == r);
  endfunction

  function automatic bit is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && (int'(ir[6:2]) inside {6, 7});
  endfunction

  // Model: phase 0 = free, 1 = waiting on the unit, 2 = writeback cycle
  bit m_valid = 1'b0;
  int m_phase, m_waited;
  bit m_mult, m_div, m_busy, m_wbv, m_exc;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_valid <= 1'b1;
      m_phase <= 0;
      m_waited <= 0;
      m_mult <= 1'b0; m_div <= 1'b0; m_busy <= 1'b0; m_wbv <= 1'b0; m_exc <= 1'b0;
    end else if (m_valid) begin
      m_mult <= 1'b0; m_div <= 1'b0; m_wbv <= 1'b0; m_exc <= 1'b0;
      if (m_phase == 0) begin
        if (is_md(DXIR) && !branch_taken) begin
          m_phase <= 1;
          m_waited <= 0;
          m_busy <= 1'b1;
          m_mult <= (DXIR[6:2] == 5'd6);
          m_div  <= (DXIR[6:2] == 5'd7);
        end
      end else if (m_phase == 1) begin
        m_waited <= (m_waited < 2**CNT_W - 1) ? m_waited + 1 : m_waited;
        if (md_ready) begin
          m_phase <= 2; m_busy <= 1'b0; m_wbv <= 1'b1; m_exc <= md_exception;
        end
`ifdef HAZARD_MD_TIMEOUT_EN
        else if (m_waited == MD_TIMEOUT) begin
          m_phase <= 2; m_busy <= 1'b0; m_wbv <= 1'b1; m_exc <= 1'b1;
        end
`endif
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  always @(negedge clock) begin
    bit e_pc, e_fd, e_bub, e_fl, lu;
    if (m_valid) begin
      lu = (DXIR[31:27] == 5'd8) && (DXIR[26:22] != 5'd0) && reads_reg(FDIR, DXIR[26:22]);
      e_pc = 1'b1; e_fd = 1'b1; e_bub = 1'b0; e_fl = 1'b0;
      if (m_phase == 1) begin
        e_pc = 1'b0; e_fd = 1'b0;
      end else if (m_phase == 2) begin
        e_bub = 1'b1;
      end else if (branch_taken) begin
        e_bub = 1'b1; e_fl = 1'b1;
      end else if (lu) begin
        e_pc = 1'b0; e_fd = 1'b0; e_bub = 1'b1;
      end
      check("pc_we", int'(pc_we), int'(e_pc));
      check("fd_we", int'(fd_we), int'(e_fd));
      check("dx_bubble", int'(dx_bubble), int'(e_bub));
      check("fd_flush", int'(fd_flush), int'(e_fl));
      check("ctrl_mult", int'(ctrl_mult), int'(m_mult));
      check("ctrl_div", int'(ctrl_div), int'(m_div));
      check("md_busy", int'(md_busy), int'(m_busy));
      check("md_wb_valid", int'(md_wb_valid), int'(m_wbv));
      check("md_exc", int'(md_exc), int'(m_exc));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic peek();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, cm, wbc, wb_at, busy_n, exc_at;
    reset_n = 1'b0; FDIR = '0; DXIR = '0;
    branch_taken = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
    tick();
    peek();
    check("rst_pc_we", int'(pc_we), 1);
    check("rst_md_busy", int'(md_busy), 0);
    check("rst_wb_valid", int'(md_wb_valid), 0);
    tick();
    reset_n = 1'b1;

    // Load-use on rs of an R-type
    DXIR = LW_R3; FDIR = ADD_R3;
    peek();
    check("lu_pc_we", int'(pc_we), 0);
    check("lu_fd_we", int'(fd_we), 0);
    check("lu_bubble", int'(dx_bubble), 1);
    tick();
    FDIR = mk(5'd0, 5'd4, 5'd7, 5'd5, 5'd0);
    peek();
    check("nolu_pc_we", int'(pc_we), 1);
    check("nolu_bubble", int'(dx_bubble), 0);
    tick();
    FDIR = mk(5'd0, 5'd4, 5'd1, 5'd3, 5'd0);
    peek();
    check("lu_rt_pc_we", int'(pc_we), 0);
    tick();
    FDIR = mk(5'd7, 5'd3, 5'd1, 5'd1, 5'd0);
    peek();
    check("lu_sw_rd_pc_we", int'(pc_we), 0);
    tick();
    FDIR = mk(5'd5, 5'd4, 5'd1, 5'd3, 5'd0);
    peek();
    check("addi_rt_no_lu", int'(pc_we), 1);
    tick();
    DXIR = mk(5'd8, 5'd0, 5'd1, 5'd0, 5'd0); FDIR = mk(5'd0, 5'd4, 5'd0, 5'd0, 5'd0);
    peek();
    check("r0_no_lu", int'(dx_bubble), 0);
    tick();

    // Taken branch over a simultaneous load-use
    DXIR = LW_R3; FDIR = ADD_R3; branch_taken = 1'b1;
    peek();
    check("br_flush", int'(fd_flush), 1);
    check("br_bubble", int'(dx_bubble), 1);
    check("br_pc_we", int'(pc_we), 1);
    check("br_fd_we", int'(fd_we), 1);
    tick();
    branch_taken = 1'b0; DXIR = '0; FDIR = '0; md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    peek();
    check("idle_ready_ignored", int'(md_wb_valid), 0);
    tick();

    // Multiply, unit answers 17 cycles after the start pulse
    DXIR = MULT_OP;
    peek();
    check("mult_pre_start", int'(ctrl_mult), 0);
    tick();
    low = 0; cm = 0; wbc = 0; wb_at = -1;
    for (int i = 1; i <= 20; i++) begin
      md_ready = (i == 18);
      DXIR = (i >= 20) ? 32'h0 : MULT_OP;
      peek();
      if (!pc_we) low++;
      if (ctrl_mult) cm++;
      if (md_wb_valid) begin wbc++; wb_at = i; end
      if (i == 19) begin
        check("mult_done_bubble", int'(dx_bubble), 1);
        check("mult_done_pc_we", int'(pc_we), 1);
        check("mult_done_exc", int'(md_exc), 0);
      end
      tick();
    end
    md_ready = 1'b0;
    check("mult_stall_cycles", low, 18);
    check("mult_pulse_cycles", cm, 1);
    check("mult_wb_count", wbc, 1);
    check("mult_wb_cycle", wb_at, 19);

    // Divide with exception, then a back-to-back multiply, then reset mid-wait
    DXIR = DIV_OP;
    tick();
    for (int i = 1; i <= 10; i++) begin
      md_ready = (i == 5);
      md_exception = (i == 5);
      DXIR = (i >= 7) ? MULT_OP : DIV_OP;
      peek();
      if (i == 1) check("div_pulse", int'(ctrl_div), 1);
      if (i == 6) begin
        check("div_wb_valid", int'(md_wb_valid), 1);
        check("div_exc", int'(md_exc), 1);
      end
      if (i == 8) begin
        check("b2b_mult_pulse", int'(ctrl_mult), 1);
        check("b2b_busy", int'(md_busy), 1);
      end
      tick();
    end
    md_ready = 1'b0; md_exception = 1'b0;
    reset_n = 1'b0; DXIR = '0;
    tick();
    reset_n = 1'b1;
    peek();
    check("rst_wait_busy", int'(md_busy), 0);
    check("rst_wait_pc_we", int'(pc_we), 1);
    tick();
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    peek();
    check("late_ready_no_wb", int'(md_wb_valid), 0);
    tick();

`ifdef HAZARD_MD_TIMEOUT_EN
    // Unit never answers: abort after the counter reaches MD_TIMEOUT
    DXIR = MULT_OP;
    tick();
    busy_n = 0; wb_at = -1; exc_at = -1;
    for (int i = 1; i <= MD_TIMEOUT + 4; i++) begin
      DXIR = (i >= MD_TIMEOUT + 3) ? 32'h0 : MULT_OP;
      peek();
      if (md_busy) busy_n++;
      if (md_wb_valid) begin wb_at = i; exc_at = int'(md_exc); end
      tick();
    end
    check("to_wait_cycles", busy_n, MD_TIMEOUT + 1);
    check("to_wb_cycle", wb_at, MD_TIMEOUT + 2);
    check("to_exc", exc_at, 1);
`else
    busy_n = 0; exc_at = 0;
`endif

    DXIR = '0; FDIR = '0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
